// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the multiply/divide unit.
// The divider is compiled in only when MDU_DIV_EN is defined.
package mdu_pkg;

    localparam int MDU_WIDTH   = 32;
    localparam int MDU_LATENCY = MDU_WIDTH + 2;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } mdu_state_e;

    function automatic logic mdu_is_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract,
// keep the difference when it does not underflow.
module mdu_div_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff_lo;

    always_comb begin
        partial = {rem_in, dividend_bit};
        q_bit   = (partial >= {1'b0, divisor});
        // When q_bit is set the true difference is below 2^WIDTH, so the low bits suffice.
        diff_lo = partial[WIDTH-1:0] - divisor;
        rem_out = q_bit ? diff_lo : partial[WIDTH-1:0];
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit feeding HI/LO.
// Divider datapath is present only when MDU_DIV_EN is defined.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q, op_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [WIDTH:0]     mul_sum;

`ifdef MDU_DIV_EN
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q_bit;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in       (acc_q[2*WIDTH-1:WIDTH]),
        .dividend_bit (a_q[WIDTH-1]),
        .divisor      (b_q),
        .rem_out      (step_rem),
        .q_bit        (step_q_bit)
    );
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
`ifdef MDU_DIV_EN
        a_raw_d  = a_raw_q;
        quot_fix = '0;
        rem_fix  = '0;
`endif
        // Shift-add: high half accumulates, whole accumulator shifts right each step.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_CALC;
                    op_d    = mdu_op_e'(op);
                    sa_d    = mdu_is_signed(op_d) & a[WIDTH-1];
                    sb_d    = mdu_is_signed(op_d) & b[WIDTH-1];
                    a_d     = sa_d ? -a : a;
                    b_d     = sb_d ? -b : b;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef MDU_DIV_EN
                    a_raw_d = a;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q inside {MDU_MULT, MDU_MULTU}) begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    b_d   = b_q >> 1;
                end else begin
`ifdef MDU_DIV_EN
                    // Remainder in the high half, quotient bits enter from the bottom.
                    acc_d = {step_rem, acc_q[WIDTH-2:0], step_q_bit};
                    a_d   = a_q << 1;
`endif
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                state_d = ST_DONE;
                if (op_q inside {MDU_MULT, MDU_MULTU}) begin
                    result_d = (sa_q ^ sb_q) ? -acc_q : acc_q;
                end else begin
`ifdef MDU_DIV_EN
                    quot_fix = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    if (b_q == '0) begin
                        result_d = {a_raw_q, {WIDTH{1'b1}}};
                    end else begin
                        result_d = {rem_fix, quot_fix};
                    end
`else
                    result_d = '0;
`endif
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= MDU_MULT;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
`ifdef MDU_DIV_EN
            a_raw_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
`ifdef MDU_DIV_EN
            a_raw_q  <= a_raw_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit; expectations follow MDU_DIV_EN.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_prev;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Reference: plain 64-bit integer arithmetic following MIPS HI/LO rules.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
`ifndef MDU_DIV_EN
        if (o[1]) return 64'h0;
`endif
        case (o)
            2'b00: return 64'(sx * sy);
            2'b01: return 64'(ux * uy);
            default: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (o == 2'b10) begin
                    q = sx / sy;
                    r = sx % sy;
                end else begin
                    q = longint'(ux / uy);
                    r = longint'(ux % uy);
                end
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic logic [63:0] build_exp(input logic [1:0] o, input logic [63:0] e);
`ifdef MDU_DIV_EN
        return e;
`else
        return o[1] ? 64'h0 : e;
`endif
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Starts at a negedge with start driven; returns at the negedge of the done cycle.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp, input string name, input int repulse);
        int busy_bad = 0;
        int done_bad = 0;
        int hold_bad = 0;
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        for (int c = 1; c <= 34; c++) begin
            if (busy !== (c <= 33)) busy_bad++;
            if (done !== (c == 34)) done_bad++;
            if (c < 34 && result !== exp_prev) hold_bad++;
            start = (c == repulse);
            if (c < 34) @(negedge clk);
        end
        start = 1'b0;
        check({name, "_busy_window"}, 64'(busy_bad), 64'h0);
        check({name, "_done_timing"}, 64'(done_bad), 64'h0);
        check({name, "_result_hold"}, 64'(hold_bad), 64'h0);
        check({name, "_result"}, result, exp);
        exp_prev = exp;
    endtask

    initial begin
        int done_seen;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        exp_prev = 64'h0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);
        check("reset_result", result, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max"});
        vecs.push_back('{2'b00, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, "mult_neg3x7"});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mult_minxmin"});
        vecs.push_back('{2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E, "divu_100_7"});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2"});
        vecs.push_back('{2'b10, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, "div_7_m2"});
        vecs.push_back('{2'b10, 32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, "div_5_0"});
        vecs.push_back('{2'b10, 32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF, "div_m5_0"});
        vecs.push_back('{2'b11, 32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, "divu_5_0"});
        vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_min_m1"});
        vecs.push_back('{2'b01, 32'd0,         32'h1234_5678, 64'h0,                   "multu_zero"});

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, build_exp(vecs[i].op, vecs[i].exp), vecs[i].name, 0);
            if (i % 2 == 1) repeat (2) @(negedge clk);
        end

        // Restart while busy must be ignored.
        do_op(2'b01, 32'd123456, 32'd789, model(2'b01, 32'd123456, 32'd789), "repulse", 5);
        @(negedge clk);

        // Reset in the middle of an operation discards it.
        op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h1234_5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("midreset_busy_before", 64'(busy), 64'h1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_busy", 64'(busy), 64'h0);
        check("midreset_result", result, 64'h0);
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("midreset_no_done", 64'(done_seen), 64'h0);
        exp_prev = 64'h0;

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1, 2: rb = 32'($urandom_range(1, 20));
                3: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            do_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rand%0d", i), 0);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
